code_emitter: RTL and testbench

- Transmit side of the sticker-code digit protocol.
- Accepts a code of 0–3 digits plus its length, then emits it serially: one single-cycle D strobe per digit, with the digit value on a bus, followed by a single-cycle C (lectura completada) strobe.
- Drives the digit-length counter FSM and the Mealy completion path.
- Used as the stimulus source in system tests and as the sticker writer in the full design.

---
 rtl/code_emitter_if.sv | 25 ++
 rtl/code_emitter.sv | 122 ++++++++++++
 tb/tb_code_emitter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/code_emitter_if.sv
// Handshake bundle between a code_emitter and whoever drives or watches it.
// The master side requests codes; the slave side is the emitter itself.
interface code_emitter_if #(
    parameter int DIGIT_W = 4
);
    logic                   start;
    logic [1:0]             len;
    logic [3*DIGIT_W-1:0]   code;
    logic                   stall;
    logic                   D;
    logic [DIGIT_W-1:0]     digit;
    logic                   C;
    logic                   busy;
    logic                   done;

    modport master (
        output start, len, code, stall,
        input  D, digit, C, busy, done
    );

    modport slave (
        input  start, len, code, stall,
        output D, digit, C, busy, done
    );
endinterface

// File: rtl/code_emitter.sv
// Serial sticker-code transmitter: one D strobe per digit, then a C strobe.
// Every output is a flop decoded from the next state, so inputs never reach outputs combinationally.
module code_emitter #(
    parameter int DIGIT_W    = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    code_emitter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, EMIT, GAP, COMPLETE, DONE
    } state_t;

    localparam logic [3:0] GAP_LAST =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t                 state, nstate;
    logic [1:0]             idx, nidx;
    logic [1:0]             len_q, nlen;
    logic [3*DIGIT_W-1:0]   code_q, ncode;
    logic [3:0]             gcnt, ngcnt;
    logic                   last, nlast;
    logic                   fin, nfin;
    logic                   frozen;
    logic [DIGIT_W-1:0]     ndigit;

    always_comb begin
        nstate = state;
        nidx   = idx;
        nlen   = len_q;
        ncode  = code_q;
        ngcnt  = gcnt;
        nlast  = last;
        nfin   = fin;
        frozen = bus.stall &&
                 (state == EMIT || state == GAP || state == COMPLETE);
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    nlen   = bus.len;
                    ncode  = bus.code;
                    nidx   = 2'd0;
                    ngcnt  = 4'd0;
                    nlast  = (bus.len <= 2'd1);
                    nfin   = 1'b0;
                    nstate = (bus.len == 2'd0) ? COMPLETE : EMIT;
                end
            end
            EMIT: begin
                // last/fin keep idx within len-1 instead of running past it
                if (!last) begin
                    nidx  = idx + 2'd1;
                    nlast = ((idx + 2'd2) == len_q);
                end
                if (GAP_CYCLES > 0) begin
                    nstate = GAP;
                    ngcnt  = 4'd0;
                    nfin   = last;
                end else begin
                    nstate = last ? COMPLETE : EMIT;
                end
            end
            GAP: begin
                if (gcnt == GAP_LAST) begin
                    nstate = fin ? COMPLETE : EMIT;
                end else begin
                    ngcnt = gcnt + 4'd1;
                end
            end
            COMPLETE: nstate = DONE;
            DONE:     nstate = IDLE;
            default:  nstate = IDLE;
        endcase
        if (frozen) begin
            nstate = state;
            nidx   = idx;
            ngcnt  = gcnt;
            nlast  = last;
            nfin   = fin;
        end
    end

    always_comb begin
        unique case (nidx)
            2'd0:    ndigit = ncode[0 +: DIGIT_W];
            2'd1:    ndigit = ncode[DIGIT_W +: DIGIT_W];
            default: ndigit = ncode[2*DIGIT_W +: DIGIT_W];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            len_q     <= 2'd0;
            code_q    <= '0;
            gcnt      <= 4'd0;
            last      <= 1'b0;
            fin       <= 1'b0;
            bus.D     <= 1'b0;
            bus.C     <= 1'b0;
            bus.digit <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            state     <= nstate;
            idx       <= nidx;
            len_q     <= nlen;
            code_q    <= ncode;
            gcnt      <= ngcnt;
            last      <= nlast;
            fin       <= nfin;
            bus.D     <= (nstate == EMIT) && !frozen;
            bus.C     <= (nstate == COMPLETE) && !frozen;
            bus.digit <= ((nstate == EMIT) && !frozen) ? ndigit : '0;
            bus.busy  <= (nstate == EMIT) || (nstate == GAP) ||
                         (nstate == COMPLETE);
            bus.done  <= (nstate == DONE);
        end
    end
endmodule

// File: tb/tb_code_emitter.sv
// Directed bench for code_emitter: gap=1 and gap=0 instances share stimulus.
// Per-cycle traces are compared against hand-derived strobe timings.
module tb_code_emitter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  len = 2'd0;
    logic [11:0] code = 12'h000;
    logic        stall = 1'b0;
    logic        sel = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  tw [0:31];

    always #5 clk = ~clk;

    code_emitter_if #(.DIGIT_W(4)) b1 ();
    code_emitter_if #(.DIGIT_W(4)) b0 ();

    assign b1.start = start;
    assign b1.len   = len;
    assign b1.code  = code;
    assign b1.stall = stall;
    assign b0.start = start;
    assign b0.len   = len;
    assign b0.code  = code;
    assign b0.stall = stall;

    code_emitter #(.DIGIT_W(4), .GAP_CYCLES(1)) u_gap1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1)
    );

    code_emitter #(.DIGIT_W(4), .GAP_CYCLES(0)) u_gap0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    function automatic logic [7:0] obs();
        if (sel)
            return {b0.D, b0.C, b0.busy, b0.done, b0.digit};
        return {b1.D, b1.C, b1.busy, b1.done, b1.digit};
    endfunction

    // {D, C, busy, done, digit} expected in cycle c
    function automatic logic [7:0] ew(
        input int c, input int d0, input int d1, input int d2,
        input logic [3:0] g0, input logic [3:0] g1,
        input logic [3:0] g2, input int cc
    );
        logic       d;
        logic [3:0] g;
        d = 1'b0;
        g = 4'd0;
        if (c == d0) begin d = 1'b1; g = g0; end
        if (c == d1) begin d = 1'b1; g = g1; end
        if (c == d2) begin d = 1'b1; g = g2; end
        return {d, (c == cc), (c >= 1 && c <= cc), (c == cc + 1), g};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic trace(input logic [1:0] l, input logic [11:0] cd,
                         input int n, input logic [31:0] smask,
                         input int rs);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        code  = cd;
        stall = smask[1];
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            tw[c] = obs();
            start = (c + 1 == rs);
            if (c + 1 == rs) begin
                len  = 2'd1;
                code = 12'h444;
            end
            stall = smask[c+1];
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic verify(input string tag, input int n,
                          input int d0, input int d1, input int d2,
                          input logic [3:0] g0, input logic [3:0] g1,
                          input logic [3:0] g2, input int cc);
        for (int c = 1; c <= n; c++)
            chk($sformatf("%s c%0d", tag, c), {24'd0, tw[c]},
                {24'd0, ew(c, d0, d1, d2, g0, g1, g2, cc)});
    endtask

    initial begin
        #12;
        sel = 1'b0;
        chk("rst gap1", {24'd0, obs()}, 32'd0);
        sel = 1'b1;
        chk("rst gap0", {24'd0, obs()}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        sel = 1'b0;
        trace(2'd3, 12'h927, 10, 32'h0, 0);
        verify("len3", 10, 1, 3, 5, 4'd7, 4'd2, 4'd9, 7);

        trace(2'd0, 12'h927, 4, 32'h0, 0);
        verify("len0", 4, -1, -1, -1, 4'd0, 4'd0, 4'd0, 1);

        sel = 1'b1;
        trace(2'd2, 12'h085, 6, 32'h0, 0);
        verify("gap0", 6, 1, 2, -1, 4'd5, 4'd8, 4'd0, 3);

        sel = 1'b0;
        trace(2'd3, 12'h927, 13, 32'h38, 0);
        verify("stall", 13, 1, 6, 8, 4'd7, 4'd2, 4'd9, 10);

        trace(2'd3, 12'h361, 10, 32'h0, 3);
        verify("restart", 10, 1, 3, 5, 4'd1, 4'd6, 4'd3, 7);

        trace(2'd3, 12'h927, 4, 32'h0, 0);
        verify("pre_abort", 4, 1, 3, -1, 4'd7, 4'd2, 4'd0, 99);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort now", {24'd0, obs()}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort c%0d", c), {24'd0, obs()}, 32'd0);
        end
        reset_n = 1'b1;

        trace(2'd3, 12'h927, 10, 32'h0, 0);
        verify("rerun", 10, 1, 3, 5, 4'd7, 4'd2, 4'd9, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
